fft_stream_checker: RTL and testbench
=====================================

// Module: fft_stream_checker
// PURPOSE
// Synthesizable, parametrised stimulus player and response checker for N-point streaming FFT cores.
// Drives N real samples into the DUT, captures 2N outputs (N real, then N imag) on the DUT's finish strobe,
// compares them against a loaded golden table and reports pass/fail, error count, first error and timeout.
// Sits beside the FFT core for on-chip self-test and FPGA bring-up.
// PARAMETERS
// N_POINTS  32   transform length; stimulus depth N, golden depth 2N
// IN_W      11   DUT input sample width
// OUT_W     17   DUT output word width (two's complement)
// TIMEOUT   150  max cycles in RUN before abort (>= N_POINTS)
// TOL       1    allowed |answer-golden| when FFT_CHK_TOL_EN defined
// ERR_W     8    error counter width (saturating)
// PORTS
// clk            in   1                 clock, all logic posedge
// rst            in   1                 synchronous active-high reset
// start          in   1                 begin run (honoured in IDLE or DONE only)
// stim_we        in   1                 stimulus memory write enable (IDLE only)
// stim_addr      in   clog2(N)          stimulus write address
// stim_wdata     in   IN_W              stimulus write data
// gold_we        in   1                 golden memory write enable (IDLE only)
// gold_addr      in   clog2(2N)         golden write address (0..N-1 real, N..2N-1 imag)
// gold_wdata     in   OUT_W             golden write data
// dut_valid_o    out  1                 to DUT valid_i
// dut_x_o        out  IN_W              to DUT x_r
// dut_finish_i   in   1                 DUT output-valid strobe
// dut_answer_i   in   OUT_W             DUT output word
// busy           out  1                 state==RUN
// done           out  1                 state==DONE
// pass           out  1                 done & all 2N matched & no timeout
// timeout        out  1                 run aborted by TIMEOUT
// err_cnt        out  ERR_W             mismatches, saturates at 2^ERR_W-1
// first_err_idx  out  clog2(2N)         index of first mismatch (valid when err_cnt!=0)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters cleared; memories NOT cleared (retain contents).
// - FSM IDLE->RUN on start; RUN->DONE on completion or timeout; DONE->RUN on start (counters/flags cleared).
// - start during RUN ignored. stim_we/gold_we outside IDLE ignored.
// - Drive: start sampled at edge 0; dut_valid_o=1 with dut_x_o=stim[k] on cycles 1..N (k=0..N-1),
//   registered outputs; otherwise dut_valid_o=0, dut_x_o=0.
// - Capture runs concurrently with drive (DUT latency may be < N): on each posedge in RUN with dut_finish_i=1,
//   compare dut_answer_i to gold[j], j++ (0..2N-1). finish outside RUN or after j==2N ignored.
// - Compare: diff = answer - golden in OUT_W+1 signed bits; mismatch if diff!=0 (see CONFIGURATION).
//   On mismatch err_cnt++ (saturating); first mismatch latches first_err_idx=j.
// - Completion: capture of j=2N-1 -> DONE next cycle; pass=(err_cnt==0 incl. that word).
// - Timeout: cycle counter from RUN entry; at TIMEOUT-1 without completion -> DONE, timeout=1, pass=0.
//   Completion and timeout in the same cycle: completion wins, timeout=0.
// - DONE holds all status outputs until rst or start.
// - rst mid-RUN: IDLE next cycle, dut_valid_o=0, status cleared, memories intact.
// CONFIGURATION
// - FFT_CHK_TOL_EN defined: mismatch only if |diff| > TOL (last-bit rounding tolerance).
// - FFT_CHK_TOL_EN undefined: exact compare; TOL unused.
// TESTING
// 1. Matching golden, DUT model latency 40 -> valid cycles 1..32, done at cycle 40+64+1, pass=1, err_cnt=0.
// 2. golden[5]+=1: with FFT_CHK_TOL_EN, TOL=1 -> pass=1; without -> pass=0, err_cnt=1, first_err_idx=5.
// 3. golden[37]+=3, golden[50]-=3 (either config) -> pass=0, err_cnt=2, first_err_idx=37.
// 4. DUT never asserts finish -> done at TIMEOUT, timeout=1, pass=0, err_cnt=0.
// 5. rst at k=10 of drive -> next cycle dut_valid_o=0, busy=0, status 0; restart w/o reload -> pass=1.
// 6. DUT latency 5 (finish during drive) plus 3 extra finish pulses after j=64 -> pass=1, err_cnt=0.

Source files
------------

// File: rtl/fft_stream_checker.sv
// Stimulus player / response checker for N-point streaming FFT cores (on-chip self-test).
// Optional feature: define FFT_CHK_TOL_EN to accept |answer-golden| <= TOL instead of exact compare.
module fft_stream_checker #(
    parameter int N_POINTS = 32,
    parameter int IN_W     = 11,
    parameter int OUT_W    = 17,
    parameter int TIMEOUT  = 150,
    parameter int TOL      = 1,
    parameter int ERR_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stim_we,
    input  logic [$clog2(N_POINTS)-1:0]     stim_addr,
    input  logic [IN_W-1:0]                 stim_wdata,
    input  logic                            gold_we,
    input  logic [$clog2(2*N_POINTS)-1:0]   gold_addr,
    input  logic [OUT_W-1:0]                gold_wdata,
    output logic                            dut_valid_o,
    output logic [IN_W-1:0]                 dut_x_o,
    input  logic                            dut_finish_i,
    input  logic [OUT_W-1:0]                dut_answer_i,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout,
    output logic [ERR_W-1:0]                err_cnt,
    output logic [$clog2(2*N_POINTS)-1:0]   first_err_idx
);

    localparam int SA_W   = $clog2(N_POINTS);
    localparam int GA_W   = $clog2(2*N_POINTS);
    localparam int GOLD_N = 2*N_POINTS;
    localparam int CYC_W  = $clog2(TIMEOUT+1);

`ifdef FFT_CHK_TOL_EN
    localparam int TOL_EFF = TOL;
`else
    localparam int TOL_EFF = 0;
`endif

    localparam logic [SA_W:0]      DRV_END  = (SA_W+1)'(N_POINTS);
    localparam logic [GA_W:0]      CAP_END  = (GA_W+1)'(GOLD_N);
    localparam logic [GA_W:0]      CAP_LAST = (GA_W+1)'(GOLD_N-1);
    localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(TIMEOUT-1);
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;
    localparam logic [OUT_W:0]     DIFF_TOL = (OUT_W+1)'(TOL_EFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [IN_W-1:0]        r_stim [N_POINTS];
    logic [OUT_W-1:0]       r_gold [GOLD_N];

    logic [SA_W:0]          r_drvIdx;
    logic                   r_valid;
    logic [IN_W-1:0]        r_x;
    logic [GA_W:0]          r_capIdx;
    logic [CYC_W-1:0]       r_cyc;
    logic [ERR_W-1:0]       r_err;
    logic [GA_W-1:0]        r_firstErr;
    logic                   r_pass;
    logic                   r_timeout;

    logic                   w_inRun;
    logic                   w_startRun;
    logic                   w_capFire;
    logic                   w_lastCap;
    logic                   w_cycExpired;
    logic                   w_timeoutHit;
    logic                   w_leaveRun;
    logic [OUT_W-1:0]       w_gold;
    logic signed [OUT_W:0]  w_diff;
    logic [OUT_W:0]         w_absDiff;
    logic                   w_mismatch;
    logic                   w_busy;
    logic                   w_done;

    assign w_inRun      = (r_state == S_RUN);
    assign w_startRun   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_capFire    = w_inRun && dut_finish_i && (r_capIdx < CAP_END);
    assign w_lastCap    = w_capFire && (r_capIdx == CAP_LAST);
    assign w_cycExpired = w_inRun && (r_cyc == CYC_LAST);
    assign w_timeoutHit = w_cycExpired && !w_lastCap;
    assign w_leaveRun   = w_lastCap || w_cycExpired;

    // Memories are loadable only while idle and keep their contents through reset.
    always_ff @(posedge clk) begin
        if (stim_we && (r_state == S_IDLE)) begin
            r_stim[stim_addr] <= stim_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (gold_we && (r_state == S_IDLE)) begin
            r_gold[gold_addr] <= gold_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE:  if (start)      w_nextState = S_RUN;
            S_RUN:   if (w_leaveRun) w_nextState = S_DONE;
            S_DONE:  if (start)      w_nextState = S_RUN;
            default:                 w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Stimulus player: one sample per cycle right after the start edge, stops early if the run ends.
    always_ff @(posedge clk) begin
        if (rst || w_startRun) begin
            r_drvIdx <= '0;
            r_valid  <= 1'b0;
            r_x      <= '0;
        end else if (w_inRun && !w_leaveRun && (r_drvIdx < DRV_END)) begin
            r_valid  <= 1'b1;
            r_x      <= r_stim[r_drvIdx[SA_W-1:0]];
            r_drvIdx <= r_drvIdx + 1'b1;
        end else begin
            r_valid  <= 1'b0;
            r_x      <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_startRun) begin
            r_cyc <= '0;
        end else if (w_inRun && (r_cyc != CYC_LAST)) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    // Sign-extend both words so the difference can never wrap.
    assign w_gold     = r_gold[r_capIdx[GA_W-1:0]];
    assign w_diff     = $signed({dut_answer_i[OUT_W-1], dut_answer_i})
                      - $signed({w_gold[OUT_W-1], w_gold});
    assign w_absDiff  = w_diff[OUT_W] ? (OUT_W+1)'(-w_diff) : (OUT_W+1)'(w_diff);
    assign w_mismatch = (w_absDiff > DIFF_TOL);

    always_ff @(posedge clk) begin
        if (rst || w_startRun) begin
            r_capIdx   <= '0;
            r_err      <= '0;
            r_firstErr <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_capFire) begin
                r_capIdx <= r_capIdx + 1'b1;
                if (w_mismatch) begin
                    if (r_err != ERR_MAX) begin
                        r_err <= r_err + 1'b1;
                    end
                    if (r_err == '0) begin
                        r_firstErr <= r_capIdx[GA_W-1:0];
                    end
                end
                if (w_lastCap) begin
                    r_pass    <= (r_err == '0) && !w_mismatch;
                    r_timeout <= 1'b0;
                end
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
            end
        end
    end

    assign dut_valid_o   = r_valid;
    assign dut_x_o       = r_x;
    assign busy          = w_busy;
    assign done          = w_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign err_cnt       = r_err;
    assign first_err_idx = r_firstErr;

endmodule

// File: tb/tb_fft_stream_checker.sv
// Directed bench for fft_stream_checker with a behavioural FFT-core stand-in and status scoreboard.
// Expectations for the tolerance case follow FFT_CHK_TOL_EN.
module tb_fft_stream_checker;

    localparam int N       = 32;
    localparam int IN_W    = 11;
    localparam int OUT_W   = 17;
    localparam int TIMEOUT = 150;
    localparam int TOL     = 1;
    localparam int ERR_W   = 8;
    localparam int SA_W    = 5;
    localparam int GA_W    = 6;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stim_we;
    logic [SA_W-1:0]    stim_addr;
    logic [IN_W-1:0]    stim_wdata;
    logic               gold_we;
    logic [GA_W-1:0]    gold_addr;
    logic [OUT_W-1:0]   gold_wdata;
    logic               dut_valid_o;
    logic [IN_W-1:0]    dut_x_o;
    logic               dut_finish_i;
    logic [OUT_W-1:0]   dut_answer_i;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic [ERR_W-1:0]   err_cnt;
    logic [GA_W-1:0]    first_err_idx;

    fft_stream_checker #(
        .N_POINTS (N),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .TIMEOUT  (TIMEOUT),
        .TOL      (TOL),
        .ERR_W    (ERR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stim_we       (stim_we),
        .stim_addr     (stim_addr),
        .stim_wdata    (stim_wdata),
        .gold_we       (gold_we),
        .gold_addr     (gold_addr),
        .gold_wdata    (gold_wdata),
        .dut_valid_o   (dut_valid_o),
        .dut_x_o       (dut_x_o),
        .dut_finish_i  (dut_finish_i),
        .dut_answer_i  (dut_answer_i),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             pass;
        logic [ERR_W-1:0] errCnt;
        logic [GA_W-1:0]  firstErr;
        logic             timeout;
        int               doneCycle;
    } status_t;

    status_t            statusQ[$];
    logic [IN_W-1:0]    xQ[$];

    logic [IN_W-1:0]    stimRef [N];
    logic [OUT_W-1:0]   outRef  [2*N];

    int  cycle;
    int  firstValid;
    int  validCnt;
    bit  modelEn;
    int  modelLat;
    int  modelExtra;
    int  assertCnt;
    int  failCnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then play the FFT core's next output word.
    task automatic tick();
        int t;
        @(posedge clk);
        #1;
        cycle++;
        if (dut_valid_o === 1'b1) begin
            if (firstValid < 0) firstValid = cycle;
            validCnt++;
            if (xQ.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
            else                checkOutput("dut_x", 32'(dut_x_o), 32'(xQ.pop_front()));
        end
        dut_finish_i = 1'b0;
        dut_answer_i = '0;
        if (modelEn && firstValid >= 0) begin
            t = cycle - firstValid - modelLat;
            if (t >= 0 && t < 2*N + modelExtra) begin
                dut_finish_i = 1'b1;
                dut_answer_i = (t < 2*N) ? outRef[t] : 17'h1ABCD;
            end
        end
    endtask

    task automatic writeStim(input int idx, input logic [IN_W-1:0] val);
        stim_we = 1'b1; stim_addr = SA_W'(idx); stim_wdata = val;
        tick();
        stim_we = 1'b0;
    endtask

    task automatic writeGold(input int idx, input logic [OUT_W-1:0] val);
        gold_we = 1'b1; gold_addr = GA_W'(idx); gold_wdata = val;
        tick();
        gold_we = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int lat, input int extra, input bit en, input bit expectDone,
                                 input logic expPass, input int expErr, input int expFirst,
                                 input logic expTimeout, input int expDoneCycle);
        status_t s;
        if (expectDone) begin
            s.pass = expPass; s.errCnt = ERR_W'(expErr); s.firstErr = GA_W'(expFirst);
            s.timeout = expTimeout; s.doneCycle = expDoneCycle;
            statusQ.push_back(s);
        end
        for (int i = 0; i < N; i++) xQ.push_back(stimRef[i]);
        modelEn = en; modelLat = lat; modelExtra = extra;
        dut_finish_i = 1'b0;
        firstValid = -1; validCnt = 0;
        cycle = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone();
        status_t s;
        while (done !== 1'b1 && cycle < 400) tick();
        if (statusQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            s = statusQ.pop_front();
            checkOutput("done_seen", 32'(done), 32'd1);
            checkOutput("done_cycle", 32'(cycle), 32'(s.doneCycle));
            checkOutput("busy_at_done", 32'(busy), 32'd0);
            checkOutput("pass", 32'(pass), 32'(s.pass));
            checkOutput("err_cnt", 32'(err_cnt), 32'(s.errCnt));
            checkOutput("timeout", 32'(timeout), 32'(s.timeout));
            if (s.errCnt != 0) checkOutput("first_err_idx", 32'(first_err_idx), 32'(s.firstErr));
            checkOutput("first_valid_cycle", 32'(firstValid), 32'd1);
            checkOutput("valid_count", 32'(validCnt), 32'(N));
            checkOutput("x_queue_drained", 32'(xQ.size()), 32'd0);
        end
    endtask

    initial begin
        int v;
        assertCnt = 0; failCnt = 0;
        rst = 1'b1; start = 1'b0; stim_we = 1'b0; stim_addr = '0; stim_wdata = '0;
        gold_we = 1'b0; gold_addr = '0; gold_wdata = '0;
        dut_finish_i = 1'b0; dut_answer_i = '0;
        modelEn = 1'b0; modelLat = 0; modelExtra = 0; firstValid = -1; validCnt = 0; cycle = 0;

        for (int i = 0; i < N; i++) stimRef[i] = IN_W'($urandom);
        for (int i = 0; i < 2*N; i++) begin
            v = int'($urandom_range(60000, 0)) - 30000;
            outRef[i] = OUT_W'(v);
        end

        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_valid", 32'(dut_valid_o), 32'd0);

        for (int i = 0; i < N; i++) writeStim(i, stimRef[i]);
        for (int i = 0; i < 2*N; i++) writeGold(i, outRef[i]);

        // Matching golden, latency 40; a start pulse mid-run must be ignored.
        applyStimulus(40, 0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1 + 40 + 2*N);
        checkOutput("busy_in_run", 32'(busy), 32'd1);
        while (cycle < 20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone();

        // Golden write while DONE is dropped; short latency with surplus finish pulses.
        writeGold(0, ~outRef[0]);
        applyStimulus(5, 3, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1 + 5 + 2*N);
        waitDone();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("hold_done", 32'(done), 32'd1);
        checkOutput("hold_pass", 32'(pass), 32'd1);
        checkOutput("hold_err_cnt", 32'(err_cnt), 32'd0);

        // Core never answers.
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, TIMEOUT);
        waitDone();

        // Off-by-one golden word; reset keeps the rest of the table.
        doReset();
        writeGold(5, outRef[5] + 17'd1);
`ifdef FFT_CHK_TOL_EN
        applyStimulus(40, 0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1 + 40 + 2*N);
`else
        applyStimulus(40, 0, 1'b1, 1'b1, 1'b0, 1, 5, 1'b0, 1 + 40 + 2*N);
`endif
        waitDone();

        doReset();
        writeGold(5, outRef[5]);
        writeGold(37, outRef[37] + 17'd3);
        writeGold(50, outRef[50] - 17'd3);
        applyStimulus(40, 0, 1'b1, 1'b1, 1'b0, 2, 37, 1'b0, 1 + 40 + 2*N);
        waitDone();

        // Reset mid-drive, then rerun from retained memories.
        doReset();
        writeGold(37, outRef[37]);
        writeGold(50, outRef[50]);
        applyStimulus(40, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        while (cycle < 11) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_valid", 32'(dut_valid_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_pass", 32'(pass), 32'd0);
        checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("midrst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        xQ.delete();
        modelEn = 1'b0;
        applyStimulus(40, 0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1 + 40 + 2*N);
        waitDone();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
